// File: rtl/video_crtc_timing_if.sv
// Signal bundle between the CRTC register file / character clock side and the raster timing generator.
interface video_crtc_timing_if;
    logic        clk_en_i;
    logic [7:0]  r0_h_total_i;
    logic [7:0]  r1_h_displayed_i;
    logic [7:0]  r2_h_sync_pos_i;
    logic [3:0]  r3_h_sync_width_i;
    logic [4:0]  r3_v_sync_width_i;
    logic [6:0]  r4_v_total_i;
    logic [4:0]  r5_v_adjust_i;
    logic [6:0]  r6_v_displayed_i;
    logic [6:0]  r7_v_sync_pos_i;
    logic [4:0]  r9_max_scan_line_i;
    logic [13:0] r1213_start_addr_i;
    logic        h_sync_o;
    logic        v_sync_o;
    logic        de_o;
    logic [13:0] ma_o;
    logic [4:0]  ra_o;
    logic        frame_o;

    modport master (
        output clk_en_i, r0_h_total_i, r1_h_displayed_i, r2_h_sync_pos_i,
               r3_h_sync_width_i, r3_v_sync_width_i, r4_v_total_i, r5_v_adjust_i,
               r6_v_displayed_i, r7_v_sync_pos_i, r9_max_scan_line_i, r1213_start_addr_i,
        input  h_sync_o, v_sync_o, de_o, ma_o, ra_o, frame_o
    );

    modport slave (
        input  clk_en_i, r0_h_total_i, r1_h_displayed_i, r2_h_sync_pos_i,
               r3_h_sync_width_i, r3_v_sync_width_i, r4_v_total_i, r5_v_adjust_i,
               r6_v_displayed_i, r7_v_sync_pos_i, r9_max_scan_line_i, r1213_start_addr_i,
        output h_sync_o, v_sync_o, de_o, ma_o, ra_o, frame_o
    );
endinterface

// File: rtl/video_crtc_timing.sv
// CRTC raster timing generator: horizontal/vertical counters, sync pulses, display enable,
// memory and scanline addresses, advanced once per character-clock enable.
module video_crtc_timing (
    input  logic               sys_clock_i,
    input  logic               sys_reset_n_i,
    video_crtc_timing_if.slave bus
);
    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_ADJUST = 1'b1;

    // A programmed sync width of zero stands for the maximum width of 16.
    function automatic logic [4:0] sync_width(input logic [4:0] w);
        return (w == 5'd0) ? 5'd16 : w;
    endfunction

    logic [7:0]  h_r, h_s;
    logic [6:0]  row_r, row_s;
    logic [4:0]  ra_cnt_r, ra_cnt_s;
    logic [0:0]  state_r, state_s;
    logic [13:0] row_addr_r, row_addr_s;
    logic [4:0]  hs_cnt_r, hs_cnt_s;
    logic [4:0]  vs_cnt_r, vs_cnt_s;
    logic        line_end_s;
    logic        frame_end_s;
    logic        vs_start_s;
    logic        de_s;
    logic [13:0] ma_s;

    logic        h_sync_r;
    logic        v_sync_r;
    logic        de_r;
    logic [13:0] ma_out_r;
    logic [4:0]  ra_out_r;
    logic        frame_r;

    // Next character position: horizontal wrap and the row/scanline/adjust sequencing at line end.
    always_comb begin
        line_end_s  = (h_r >= bus.r0_h_total_i);
        h_s         = h_r;
        row_s       = row_r;
        ra_cnt_s    = ra_cnt_r;
        state_s     = state_r;
        row_addr_s  = row_addr_r;
        frame_end_s = 1'b0;
        if (line_end_s) begin
            h_s = 8'd0;
            case (state_r)
                ST_ACTIVE: begin
                    if (ra_cnt_r < bus.r9_max_scan_line_i) begin
                        ra_cnt_s = ra_cnt_r + 5'd1;
                    end else begin
                        ra_cnt_s   = 5'd0;
                        row_addr_s = row_addr_r + {6'd0, bus.r1_h_displayed_i};
                        if (row_r >= bus.r4_v_total_i) begin
                            if (bus.r5_v_adjust_i == 5'd0) begin
                                frame_end_s = 1'b1;
                                row_s       = 7'd0;
                                row_addr_s  = bus.r1213_start_addr_i;
                            end else begin
                                state_s = ST_ADJUST;
                            end
                        end else begin
                            row_s = row_r + 7'd1;
                        end
                    end
                end
                ST_ADJUST: begin
                    if (({1'b0, ra_cnt_r} + 6'd1) >= {1'b0, bus.r5_v_adjust_i}) begin
                        frame_end_s = 1'b1;
                        row_s       = 7'd0;
                        ra_cnt_s    = 5'd0;
                        state_s     = ST_ACTIVE;
                        row_addr_s  = bus.r1213_start_addr_i;
                    end else begin
                        ra_cnt_s = ra_cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_s  = ST_ACTIVE;
                    ra_cnt_s = 5'd0;
                end
            endcase
        end else begin
            h_s = h_r + 8'd1;
        end
    end

    // Sync width counters; a fresh start while still active reloads the full width.
    always_comb begin
        vs_start_s = line_end_s && (state_s == ST_ACTIVE) && (ra_cnt_s == 5'd0) &&
                     (row_s == bus.r7_v_sync_pos_i) &&
                     (bus.r7_v_sync_pos_i <= bus.r4_v_total_i);
        if (h_s == bus.r2_h_sync_pos_i) begin
            hs_cnt_s = sync_width({1'b0, bus.r3_h_sync_width_i});
        end else if (hs_cnt_r != 5'd0) begin
            hs_cnt_s = hs_cnt_r - 5'd1;
        end else begin
            hs_cnt_s = 5'd0;
        end
        if (vs_start_s) begin
            vs_cnt_s = sync_width(bus.r3_v_sync_width_i);
        end else if (line_end_s && (vs_cnt_r != 5'd0)) begin
            vs_cnt_s = vs_cnt_r - 5'd1;
        end else begin
            vs_cnt_s = vs_cnt_r;
        end
    end

    // Display enable and memory address for the position the counters move to.
    always_comb begin
        de_s = (h_s < bus.r1_h_displayed_i) && (row_s < bus.r6_v_displayed_i) &&
               (state_s == ST_ACTIVE);
        ma_s = row_addr_s + {6'd0, h_s};
    end

    // Counter state, advanced only on character-clock enables.
    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_n_i) begin
            h_r        <= 8'd0;
            row_r      <= 7'd0;
            ra_cnt_r   <= 5'd0;
            state_r    <= ST_ACTIVE;
            row_addr_r <= 14'd0;
            hs_cnt_r   <= 5'd0;
            vs_cnt_r   <= 5'd0;
        end else if (bus.clk_en_i) begin
            h_r        <= h_s;
            row_r      <= row_s;
            ra_cnt_r   <= ra_cnt_s;
            state_r    <= state_s;
            row_addr_r <= row_addr_s;
            hs_cnt_r   <= hs_cnt_s;
            vs_cnt_r   <= vs_cnt_s;
        end
    end

    // Registered outputs; frame_o is a single system-clock pulse after the enable that starts a frame.
    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_n_i) begin
            h_sync_r <= 1'b0;
            v_sync_r <= 1'b0;
            de_r     <= 1'b0;
            ma_out_r <= 14'd0;
            ra_out_r <= 5'd0;
            frame_r  <= 1'b0;
        end else if (bus.clk_en_i) begin
            h_sync_r <= (hs_cnt_s != 5'd0);
            v_sync_r <= (vs_cnt_s != 5'd0);
            de_r     <= de_s;
            ma_out_r <= ma_s;
            ra_out_r <= ra_cnt_s;
            frame_r  <= frame_end_s;
        end else begin
            frame_r  <= 1'b0;
        end
    end

    assign bus.h_sync_o = h_sync_r;
    assign bus.v_sync_o = v_sync_r;
    assign bus.de_o     = de_r;
    assign bus.ma_o     = ma_out_r;
    assign bus.ra_o     = ra_out_r;
    assign bus.frame_o  = frame_r;
endmodule

// File: tb/tb_video_crtc_timing.sv
// Bench for video_crtc_timing: fixed vector table, reset/frame sequences and randomized configs
// checked against an arithmetic raster model.
module tb_video_crtc_timing;
    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    video_crtc_timing_if bus ();

    video_crtc_timing dut (
        .sys_clock_i   (clk),
        .sys_reset_n_i (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [7:0]  r2;
        logic [3:0]  r3h;
        logic [4:0]  r3v;
        logic [6:0]  r4;
        logic [4:0]  r5;
        logic [6:0]  r6;
        logic [6:0]  r7;
        logic [4:0]  r9;
        logic [13:0] start;
    } cfg_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [13:0] ma;
        logic [4:0]  ra;
        logic        fr;
    } out_t;

    typedef struct {
        cfg_t cfg;
        int   n;
        out_t exp;
    } vec_t;

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.r0 = 8'd9;  c.r1 = 8'd4;  c.r2 = 8'd6;  c.r3h = 4'd2; c.r3v = 5'd1;
        c.r4 = 7'd3;  c.r5 = 5'd1;  c.r6 = 7'd2;  c.r7 = 7'd2;  c.r9 = 5'd1;
        c.start = 14'h0100;
        return c;
    endfunction

    // Expected outputs after n character enables since reset, from frame geometry alone.
    function automatic out_t model(input cfg_t c, input int n, input bit en);
        out_t o;
        int hp, h, g, act, lpf, f, lf, row, ra, base, w, v, lstart;
        bit adj;
        o = '0;
        if (n == 0) return o;
        hp  = int'(c.r0) + 1;
        h   = n % hp;
        g   = n / hp;
        act = (int'(c.r4) + 1) * (int'(c.r9) + 1);
        lpf = act + int'(c.r5);
        f   = g / lpf;
        lf  = g % lpf;
        adj = (lf >= act);
        if (!adj) begin
            row = lf / (int'(c.r9) + 1);
            ra  = lf % (int'(c.r9) + 1);
        end else begin
            row = int'(c.r4) + 1;
            ra  = lf - act;
        end
        base = (f == 0) ? 0 : int'(c.start);
        o.ma = 14'((base + row * int'(c.r1) + h) % 16384);
        o.ra = 5'(ra);
        o.de = (h < int'(c.r1)) && (row < int'(c.r6)) && !adj;
        w = (c.r3h == 4'd0) ? 16 : int'(c.r3h);
        for (int j = 0; j < w; j++)
            if ((n - j) >= 1 && ((n - j) % hp) == int'(c.r2)) o.hs = 1'b1;
        v = (c.r3v == 5'd0) ? 16 : int'(c.r3v);
        lstart = int'(c.r7) * (int'(c.r9) + 1);
        if (c.r7 <= c.r4)
            for (int k = 0; k < v; k++)
                if ((g - k) >= 1 && ((g - k) % lpf) == lstart) o.vs = 1'b1;
        o.fr = en && ((n % (hp * lpf)) == 0);
        return o;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        bus.r0_h_total_i       = c.r0;
        bus.r1_h_displayed_i   = c.r1;
        bus.r2_h_sync_pos_i    = c.r2;
        bus.r3_h_sync_width_i  = c.r3h;
        bus.r3_v_sync_width_i  = c.r3v;
        bus.r4_v_total_i       = c.r4;
        bus.r5_v_adjust_i      = c.r5;
        bus.r6_v_displayed_i   = c.r6;
        bus.r7_v_sync_pos_i    = c.r7;
        bus.r9_max_scan_line_i = c.r9;
        bus.r1213_start_addr_i = c.start;
    endtask

    task automatic step(input logic en);
        bus.clk_en_i = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.clk_en_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check(input string tag, input int idx, input out_t exp);
        out_t got;
        got.hs = bus.h_sync_o;
        got.vs = bus.v_sync_o;
        got.de = bus.de_o;
        got.ma = bus.ma_o;
        got.ra = bus.ra_o;
        got.fr = bus.frame_o;
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got hs=%b vs=%b de=%b ma=%h ra=%0d fr=%b, expected hs=%b vs=%b de=%b ma=%h ra=%0d fr=%b",
                     tag, idx, got.hs, got.vs, got.de, got.ma, got.ra, got.fr,
                     exp.hs, exp.vs, exp.de, exp.ma, exp.ra, exp.fr);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input cfg_t c, input int n, input logic hs, input logic vs,
                                input logic de, input logic [13:0] ma, input logic [4:0] ra,
                                input logic fr);
        vec_t v;
        v.cfg = c;
        v.n   = n;
        v.exp = '{hs: hs, vs: vs, de: de, ma: ma, ra: ra, fr: fr};
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        cfg_t base, c5, c6, rc;
        out_t zero_out;
        int   n, pulses, first_n;
        logic en;

        base = base_cfg();
        c5 = base; c5.r3h = 4'd0; c5.r3v = 5'd0;
        c6 = base; c6.start = 14'h3FFE; c6.r5 = 5'd0;
        zero_out = '0;

        vecs.push_back(mk(base,   0, 1'b0, 1'b0, 1'b0, 14'h0000, 5'd0, 1'b0));
        vecs.push_back(mk(base,   1, 1'b0, 1'b0, 1'b1, 14'h0001, 5'd0, 1'b0));
        vecs.push_back(mk(base,   6, 1'b1, 1'b0, 1'b0, 14'h0006, 5'd0, 1'b0));
        vecs.push_back(mk(base,   7, 1'b1, 1'b0, 1'b0, 14'h0007, 5'd0, 1'b0));
        vecs.push_back(mk(base,   8, 1'b0, 1'b0, 1'b0, 14'h0008, 5'd0, 1'b0));
        vecs.push_back(mk(base,  23, 1'b0, 1'b0, 1'b1, 14'h0007, 5'd0, 1'b0));
        vecs.push_back(mk(base,  45, 1'b0, 1'b1, 1'b0, 14'h000D, 5'd0, 1'b0));
        vecs.push_back(mk(base,  55, 1'b0, 1'b0, 1'b0, 14'h000D, 5'd1, 1'b0));
        vecs.push_back(mk(base,  82, 1'b0, 1'b0, 1'b0, 14'h0012, 5'd0, 1'b0));
        vecs.push_back(mk(base,  90, 1'b0, 1'b0, 1'b1, 14'h0100, 5'd0, 1'b1));
        vecs.push_back(mk(base, 120, 1'b0, 1'b0, 1'b1, 14'h0104, 5'd1, 1'b0));
        vecs.push_back(mk(base, 136, 1'b1, 1'b1, 1'b0, 14'h010E, 5'd0, 1'b0));
        vecs.push_back(mk(c6,    75, 1'b0, 1'b0, 1'b0, 14'h0011, 5'd1, 1'b0));
        vecs.push_back(mk(c6,    80, 1'b0, 1'b0, 1'b1, 14'h3FFE, 5'd0, 1'b1));
        vecs.push_back(mk(c6,    81, 1'b0, 1'b0, 1'b1, 14'h3FFF, 5'd0, 1'b0));
        vecs.push_back(mk(c6,    82, 1'b0, 1'b0, 1'b1, 14'h0000, 5'd0, 1'b0));
        vecs.push_back(mk(c6,    83, 1'b0, 1'b0, 1'b1, 14'h0001, 5'd0, 1'b0));
        vecs.push_back(mk(c5,     5, 1'b0, 1'b0, 1'b0, 14'h0005, 5'd0, 1'b0));
        vecs.push_back(mk(c5,     6, 1'b1, 1'b0, 1'b0, 14'h0006, 5'd0, 1'b0));
        vecs.push_back(mk(c5,    21, 1'b1, 1'b0, 1'b1, 14'h0005, 5'd0, 1'b0));
        vecs.push_back(mk(c5,    35, 1'b1, 1'b0, 1'b0, 14'h0009, 5'd1, 1'b0));
        vecs.push_back(mk(c5,    95, 1'b1, 1'b1, 1'b0, 14'h0105, 5'd0, 1'b0));

        rst_n = 1'b0;
        bus.clk_en_i = 1'b0;
        apply_cfg(base);

        // Table: reset, program, advance n characters, compare.
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            apply_cfg(vecs[i].cfg);
            for (int k = 0; k < vecs[i].n; k++) step(1'b1);
            check("vec", i, vecs[i].exp);
        end

        // frame_o: one short pulse per 90 enables even with idle cycles between enables.
        do_reset();
        apply_cfg(base);
        pulses = 0; first_n = -1; n = 0;
        for (int i = 0; i < 362; i++) begin
            en = (i % 2 == 0);
            step(en);
            if (en) n++;
            if (bus.frame_o === 1'b1) begin
                pulses++;
                if (first_n < 0) first_n = n;
            end
        end
        check_int("frame_pulses", pulses, 2);
        check_int("frame_first", first_n, 90);

        // Reset in row 2 with no enable, then the first line end 10 enables later.
        do_reset();
        apply_cfg(base);
        for (int k = 0; k < 47; k++) step(1'b1);
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        check("rst_mid", 0, zero_out);
        for (int k = 0; k < 9; k++) step(1'b1);
        check("rst_mid", 1, '{hs: 1'b0, vs: 1'b0, de: 1'b0, ma: 14'h0009, ra: 5'd0, fr: 1'b0});
        step(1'b1);
        check("rst_mid", 2, '{hs: 1'b0, vs: 1'b0, de: 1'b1, ma: 14'h0000, ra: 5'd1, fr: 1'b0});

        // Randomized configurations and enable patterns against the model.
        for (int t = 0; t < 10; t++) begin
            rc.r0    = 8'($urandom_range(0, 12));
            rc.r1    = 8'($urandom_range(0, 14));
            rc.r2    = 8'($urandom_range(0, 13));
            rc.r3h   = 4'($urandom_range(0, 15));
            rc.r3v   = 5'($urandom_range(0, 20));
            rc.r4    = 7'($urandom_range(0, 4));
            rc.r5    = 5'($urandom_range(0, 3));
            rc.r6    = 7'($urandom_range(0, 6));
            rc.r7    = 7'($urandom_range(0, 5));
            rc.r9    = 5'($urandom_range(0, 3));
            rc.start = 14'($urandom);
            do_reset();
            apply_cfg(rc);
            n = 0;
            check("rand_rst", t, model(rc, 0, 1'b0));
            for (int i = 0; i < 300; i++) begin
                en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 199) == 0) begin
                    rst_n = 1'b0;
                    step(en);
                    rst_n = 1'b1;
                    n = 0;
                    check("rand_rst", t, model(rc, 0, 1'b0));
                end else begin
                    step(en);
                    if (en) n++;
                    check("rand", t, model(rc, n, en));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
